sar_adc_scan: RTL and testbench
===============================

// Module: sar_adc_scan
// PURPOSE
//  Multi-channel SAR ADC sequencer that drives the AFE sample/hold, the DAC1 trial value and the input mux.
//  Sits between core_a0 and the analog top: produces SAMPL_SEL, DAC1_V, DAC1_EN, SH_RST and SH_HOLD.
//  Consumes the DAC1 comparator output (COMP_O).
//  Scans the enabled channels round-robin and returns one 10-bit result per channel over a valid/ready handshake.
// PARAMETERS
//  NCH    18  number of analog channels; width of sampl_sel and ch_mask
//  DACW   10  DAC/result width (SAR bits)
//  T_SEL   4  mux settle cycles per channel (>=1)
//  T_RST   4  sample-cap reset cycles (>=1)
//  T_BIT   4  cycles per SAR bit (>=3, covers 2-FF comparator sync)
// PORTS
//  i_clk      in   1     system clock (mclk)
//  i_rstz     in   1     asynchronous active-low reset
//  scan_en    in   1     1 = run scanning; 0 = abort to IDLE
//  ch_mask    in   NCH   channel enable mask; bit n enables channel n
//  comp_i     in   1     DAC1 comparator, async; 1 = input >= DAC; synced 2-FF internally
//  sampl_sel  out  NCH   one-hot analog mux select
//  dac_en     out  1     DAC1 enable
//  dac_v      out  DACW  DAC1 trial code
//  sh_rst     out  1     sample/hold reset
//  sh_hold    out  1     sample/hold hold
//  res_vld    out  1     result valid; held until res_rdy
//  res_rdy    in   1     consumer accepts result
//  res_ch     out  5     channel index of result
//  res_dat    out  DACW  conversion result
//  busy       out  1     1 whenever state != IDLE
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; channel pointer = NCH-1, so the first scan starts at ch0; sync FFs 0.
//  States: IDLE -> SEL -> RST -> HOLD -> BIT -> OUT -> SEL (next channel) | IDLE.
//  IDLE:
//   - leave to SEL when scan_en=1 and ch_mask!=0.
//   - channel = first set mask bit strictly after the pointer, wrapping modulo NCH.
//  SEL:
//   - sampl_sel one-hot on the channel for T_SEL cycles.
//   - sampl_sel stays asserted through SEL, RST, HOLD and BIT; it is 0 in IDLE and OUT.
//  RST: sh_rst=1 for T_RST cycles.
//  HOLD:
//   - 1 cycle: sh_hold=1 and dac_en=1; sar register cleared.
//   - sh_hold and dac_en stay 1 through BIT.
//  BIT, for b = DACW-1 down to 0:
//   - dac_v = sar | (1<<b) for T_BIT cycles.
//   - On the last cycle of the bit, sync'd comp sampled: 1 keeps bit b, 0 clears it.
//  After bit 0:
//   - res_dat = sar, res_ch = channel, res_vld = 1, go to OUT.
//   - dac_en, sh_hold and dac_v drop to 0.
//  OUT:
//   - res_vld, res_dat and res_ch are held stable until res_vld & res_rdy (stall with no loss).
//   - On acceptance: res_vld = 0; pointer = channel; go to SEL if scan_en & |ch_mask, else IDLE.
//  Latency (defaults): SEL entered at cycle 0 -> res_vld=1 at cycle 49 (4+4+1+10*4).
//   - res_rdy held high -> next SEL the cycle after acceptance.
//  Mask rules:
//   - ch_mask is sampled only on channel selection; changes during a conversion do not disturb it.
//   - Single enabled channel: that channel repeats.
//  Abort: scan_en=0 in any state except OUT -> next cycle IDLE, all outputs 0, no result.
//   - In OUT the pending result is still delivered, then IDLE.
//  Arithmetic: sar is DACW bits, no carry; result 0..2^DACW-1; comp stuck 1 -> all ones, stuck 0 -> 0.
//  res_ch is the binary channel index, zero-extended to 5 bits.
// TESTING
//  1. Ideal comparator model (comp = vin >= dac_v), vin=0x2A5, mask=ch3 only
//     -> res_ch=3, res_dat=0x2A5, res_vld at cycle 49.
//  2. mask=0x00011 (ch0, ch4), res_rdy=1
//     -> results in order ch0, ch4, ch0, ch4; sampl_sel shows 0x00001, then 0x00010.
//  3. Extremes: comp stuck 1 -> res_dat=0x3FF; comp stuck 0 -> res_dat=0x000.
//     Both cases: dac_v sequence starts 0x200.
//  4. res_rdy=0 for 20 cycles in OUT -> res_vld, res_dat and res_ch stable; no new SEL.
//     Accept -> next channel starts.
//  5. scan_en=0 during BIT bit 5 -> IDLE next cycle, all outputs 0, no res_vld.
//     scan_en=1 again -> restarts at next enabled channel after last accepted.
//  6. Assert i_rstz=0 mid-RST -> all outputs 0 immediately; after release with mask=ch17, first result has res_ch=17.

Source files
------------

// File: rtl/sar_adc_scan.sv
// Multi-channel SAR ADC sequencer: scans enabled channels round-robin, drives mux/S&H/DAC1,
// and returns one DACW-bit result per channel over a valid/ready handshake.
module sar_adc_scan #(
  parameter int NCH   = 18,
  parameter int DACW  = 10,
  parameter int T_SEL = 4,
  parameter int T_RST = 4,
  parameter int T_BIT = 4
) (
  input  logic              i_clk,
  input  logic              i_rstz,
  input  logic              scan_en,
  input  logic [NCH-1:0]    ch_mask,
  input  logic              comp_i,
  output logic [NCH-1:0]    sampl_sel,
  output logic              dac_en,
  output logic [DACW-1:0]   dac_v,
  output logic              sh_rst,
  output logic              sh_hold,
  output logic              res_vld,
  input  logic              res_rdy,
  output logic [4:0]        res_ch,
  output logic [DACW-1:0]   res_dat,
  output logic              busy,
  output logic [2:0]        dbg_state
);

  localparam int CHW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int BW   = (DACW > 1) ? $clog2(DACW) : 1;
  localparam int TMAX = (T_SEL > T_RST) ? ((T_SEL > T_BIT) ? T_SEL : T_BIT)
                                        : ((T_RST > T_BIT) ? T_RST : T_BIT);
  localparam int CNTW = $clog2(TMAX + 1);

  localparam logic [CNTW-1:0] SEL_LAST = CNTW'(T_SEL - 1);
  localparam logic [CNTW-1:0] RST_LAST = CNTW'(T_RST - 1);
  localparam logic [CNTW-1:0] BIT_LAST = CNTW'(T_BIT - 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_SEL  = 3'd1;
  localparam logic [2:0] S_RST  = 3'd2;
  localparam logic [2:0] S_HOLD = 3'd3;
  localparam logic [2:0] S_BIT  = 3'd4;
  localparam logic [2:0] S_OUT  = 3'd5;

  logic [2:0]      state_q, state_d;
  logic [CHW-1:0]  ch_q, ch_d;
  logic [CHW-1:0]  ptr_q, ptr_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [BW-1:0]   bit_q, bit_d;
  logic [DACW-1:0] sar_q, sar_d;
  logic            sync1_q, sync2_q;

  // First enabled channel strictly after base, wrapping; base itself is the last candidate.
  function automatic logic [CHW-1:0] next_ch(input logic [CHW-1:0] base,
                                             input logic [NCH-1:0] mask);
    logic [CHW-1:0] sel;
    logic [CHW-1:0] idx;
    logic           found;
    sel   = base;
    found = 1'b0;
    for (int i = 1; i <= NCH; i++) begin
      idx = CHW'((int'(base) + i) % NCH);
      if (!found && mask[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sar_d   = sar_q;
    case (state_q)
      S_IDLE: begin
        if (scan_en && (|ch_mask)) begin
          ch_d    = next_ch(ptr_q, ch_mask);
          cnt_d   = '0;
          state_d = S_SEL;
        end
      end
      S_SEL: begin
        if (cnt_q == SEL_LAST) begin
          cnt_d   = '0;
          state_d = S_RST;
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end
      S_RST: begin
        if (cnt_q == RST_LAST) begin
          cnt_d   = '0;
          state_d = S_HOLD;
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end
      S_HOLD: begin
        sar_d   = '0;
        bit_d   = BW'(DACW - 1);
        cnt_d   = '0;
        state_d = S_BIT;
      end
      S_BIT: begin
        if (cnt_q == BIT_LAST) begin
          sar_d[bit_q] = sync2_q;
          cnt_d        = '0;
          if (bit_q == '0) begin
            state_d = S_OUT;
          end else begin
            bit_d = bit_q - BW'(1);
          end
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end
      S_OUT: begin
        // Valid/ready: res_vld stays high with res_ch/res_dat frozen until a cycle
        // where res_vld & res_rdy are both high; the result is consumed at that edge.
        if (res_rdy) begin
          ptr_d = ch_q;
          if (scan_en && (|ch_mask)) begin
            ch_d    = next_ch(ch_q, ch_mask);
            cnt_d   = '0;
            state_d = S_SEL;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    // A pending result is never dropped; everywhere else scan_en low aborts.
    if (!scan_en && (state_q != S_OUT)) begin
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstz) begin
    if (!i_rstz) begin
      state_q <= S_IDLE;
      ch_q    <= '0;
      ptr_q   <= CHW'(NCH - 1);
      cnt_q   <= '0;
      bit_q   <= '0;
      sar_q   <= '0;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sar_q   <= sar_d;
      sync1_q <= comp_i;
      sync2_q <= sync1_q;
    end
  end

  logic active;
  logic converting;
  assign active     = (state_q == S_SEL) || (state_q == S_RST) ||
                      (state_q == S_HOLD) || (state_q == S_BIT);
  assign converting = (state_q == S_HOLD) || (state_q == S_BIT);

  assign sampl_sel = active ? (NCH'(1) << ch_q) : '0;
  assign dac_en    = converting;
  assign sh_hold   = converting;
  assign sh_rst    = (state_q == S_RST);
  assign dac_v     = (state_q == S_BIT) ? (sar_q | (DACW'(1) << bit_q)) : '0;
  assign res_vld   = (state_q == S_OUT);
  assign res_dat   = (state_q == S_OUT) ? sar_q : '0;
  assign res_ch    = (state_q == S_OUT) ? 5'(ch_q) : 5'd0;
  assign busy      = (state_q != S_IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_sar_adc_scan.sv
// Bench for sar_adc_scan: directed scans with a comparator model; results are checked
// against an expected queue by a monitor that pops on every accepted handshake.
module tb_sar_adc_scan;
  localparam int NCH  = 18;
  localparam int DACW = 10;

  logic            i_clk;
  logic            i_rstz;
  logic            scan_en;
  logic [NCH-1:0]  ch_mask;
  logic            comp_i;
  logic [NCH-1:0]  sampl_sel;
  logic            dac_en;
  logic [DACW-1:0] dac_v;
  logic            sh_rst;
  logic            sh_hold;
  logic            res_vld;
  logic            res_rdy;
  logic [4:0]      res_ch;
  logic [DACW-1:0] res_dat;
  logic            busy;
  logic [2:0]      dbg_state;

  logic [1:0]      comp_mode;  // 0 ideal, 1 stuck high, 2 stuck low
  logic [DACW-1:0] vin;

  int n_tests = 0;
  int n_fail  = 0;
  logic [14:0]    exp_q[$];
  logic [NCH-1:0] sel_exp_q[$];
  logic           sel_chk;
  logic [NCH-1:0] prev_sel;
  logic [14:0]    mon_e;

  sar_adc_scan dut (
    .i_clk(i_clk), .i_rstz(i_rstz), .scan_en(scan_en), .ch_mask(ch_mask),
    .comp_i(comp_i), .sampl_sel(sampl_sel), .dac_en(dac_en), .dac_v(dac_v),
    .sh_rst(sh_rst), .sh_hold(sh_hold), .res_vld(res_vld), .res_rdy(res_rdy),
    .res_ch(res_ch), .res_dat(res_dat), .busy(busy), .dbg_state(dbg_state)
  );

  // clock / comparator model
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;
  assign comp_i = (comp_mode == 2'd0) ? (vin >= dac_v) : (comp_mode == 2'd1);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // monitor / scoreboard
  always @(negedge i_clk) begin
    if (res_vld && res_rdy) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_result: got ch %0d dat 0x%0h, expected no result", res_ch, res_dat);
      end else begin
        mon_e = exp_q.pop_front();
        check("result_ch", 32'(res_ch), 32'(mon_e[14:10]));
        check("result_dat", 32'(res_dat), 32'(mon_e[9:0]));
      end
    end
    if (sel_chk && (sampl_sel != '0) && (prev_sel == '0)) begin
      if (sel_exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_sel: got 0x%0h, expected no selection", sampl_sel);
      end else begin
        check("sel_onehot", 32'(sampl_sel), 32'(sel_exp_q.pop_front()));
      end
    end
    prev_sel = sampl_sel;
  end

  // driver tasks
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    i_rstz = 1'b0;
    tick();
    tick();
    i_rstz = 1'b1;
    tick();
  endtask

  task automatic push_exp(input logic [4:0] ch, input logic [DACW-1:0] dat);
    exp_q.push_back({ch, dat});
  endtask

  task automatic check_quiet(input string name);
    check({name, "_sel"}, 32'(sampl_sel), 32'd0);
    check({name, "_dac"}, {29'd0, dac_en, sh_hold, sh_rst}, 32'd0);
    check({name, "_dacv"}, 32'(dac_v), 32'd0);
    check({name, "_res"}, {16'd0, res_vld, res_ch, res_dat}, 32'd0);
    check({name, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  // which: 0 res_vld, 1 dac_en, 2 sh_rst
  task automatic wait_for(input int which, input string name);
    int   n;
    logic hit;
    n   = 0;
    hit = 1'b0;
    while (!hit && n < 200) begin
      case (which)
        0:       hit = res_vld;
        1:       hit = dac_en;
        default: hit = sh_rst;
      endcase
      if (!hit) begin
        tick();
        n++;
      end
    end
    n_tests++;
    if (!hit) begin
      n_fail++;
      $display("FAIL %s: got no event in 200 cycles, expected event", name);
    end
  endtask

  // Accepts n results with res_rdy high, dropping scan_en so the last one ends the scan.
  task automatic take_results(input int n, input string name);
    int got;
    int cyc;
    got = 0;
    cyc = 0;
    while (got < n && cyc < 400) begin
      if (res_vld && res_rdy) begin
        got++;
        if (got == n) scan_en = 1'b0;
      end
      tick();
      cyc++;
    end
    n_tests++;
    if (got < n) begin
      n_fail++;
      $display("FAIL %s: got %0d results, expected %0d", name, got, n);
    end
  endtask

  initial begin
    int cyc;
    i_rstz    = 1'b0;
    scan_en   = 1'b0;
    ch_mask   = '0;
    res_rdy   = 1'b0;
    comp_mode = 2'd0;
    vin       = '0;
    sel_chk   = 1'b0;
    prev_sel  = '0;
    tick();
    tick();
    check_quiet("reset");
    check("reset_state", 32'(dbg_state), 32'd0);
    i_rstz = 1'b1;
    tick();

    // ch3 only, ideal comparator, latency from SEL entry
    ch_mask = 18'h00008;
    vin     = 10'h2A5;
    push_exp(5'd3, 10'h2A5);
    scan_en = 1'b1;
    tick();
    check("t1_busy", {31'd0, busy}, 32'd1);
    check("t1_sel", 32'(sampl_sel), 32'h8);
    cyc = 0;
    while (!res_vld && cyc < 200) begin
      tick();
      cyc++;
    end
    check("t1_latency", 32'(cyc), 32'd49);
    res_rdy = 1'b1;
    scan_en = 1'b0;
    tick();
    res_rdy = 1'b0;
    check("t1_idle_busy", {31'd0, busy}, 32'd0);

    // ch0 and ch4 alternate from reset
    do_reset();
    ch_mask = 18'h00011;
    vin     = 10'h133;
    res_rdy = 1'b1;
    for (int i = 0; i < 2; i++) begin
      push_exp(5'd0, 10'h133);
      push_exp(5'd4, 10'h133);
      sel_exp_q.push_back(18'h00001);
      sel_exp_q.push_back(18'h00010);
    end
    sel_chk = 1'b1;
    scan_en = 1'b1;
    take_results(4, "t2_results");
    sel_chk = 1'b0;
    check("t2_sel_seen", 32'(sel_exp_q.size()), 32'd0);

    // comparator stuck high, then stuck low
    ch_mask   = 18'h00020;
    comp_mode = 2'd1;
    push_exp(5'd5, 10'h3FF);
    scan_en = 1'b1;
    wait_for(1, "t3_hold_hi");
    tick();
    check("t3_hi_dac0", 32'(dac_v), 32'h200);
    repeat (4) tick();
    check("t3_hi_dac1", 32'(dac_v), 32'h300);
    take_results(1, "t3_hi_result");
    comp_mode = 2'd2;
    push_exp(5'd5, 10'h000);
    scan_en = 1'b1;
    wait_for(1, "t3_hold_lo");
    tick();
    check("t3_lo_dac0", 32'(dac_v), 32'h200);
    repeat (4) tick();
    check("t3_lo_dac1", 32'(dac_v), 32'h100);
    take_results(1, "t3_lo_result");

    // stall 20 cycles in OUT, then accept and move to ch2
    comp_mode = 2'd0;
    ch_mask   = 18'h00006;
    vin       = 10'h155;
    res_rdy   = 1'b0;
    push_exp(5'd1, 10'h155);
    scan_en = 1'b1;
    wait_for(0, "t4_vld");
    for (int i = 0; i < 20; i++) begin
      check("t4_vld_hold", {31'd0, res_vld}, 32'd1);
      check("t4_ch_hold", 32'(res_ch), 32'd1);
      check("t4_dat_hold", 32'(res_dat), 32'h155);
      check("t4_no_sel", 32'(sampl_sel), 32'd0);
      tick();
    end
    res_rdy = 1'b1;
    tick();
    res_rdy = 1'b0;
    check("t4_next_sel", 32'(sampl_sel), 32'h4);

    // abort during bit 5 of the ch2 conversion, then restart
    repeat (26) tick();
    check("t5_dac_bit5", 32'(dac_v), 32'h160);
    scan_en = 1'b0;
    tick();
    check_quiet("t5_abort");
    repeat (5) tick();
    check("t5_no_vld", {31'd0, res_vld}, 32'd0);
    push_exp(5'd2, 10'h155);
    res_rdy = 1'b1;
    scan_en = 1'b1;
    tick();
    check("t5_restart_sel", 32'(sampl_sel), 32'h4);
    take_results(1, "t5_result");

    // async reset in RST, then ch17 only
    ch_mask = 18'h00008;
    vin     = 10'h0F0;
    scan_en = 1'b1;
    wait_for(2, "t6_rst");
    #2;
    i_rstz = 1'b0;
    #1;
    check_quiet("t6_reset");
    tick();
    tick();
    i_rstz  = 1'b1;
    ch_mask = 18'h20000;
    push_exp(5'd17, 10'h0F0);
    take_results(1, "t6_result");

    repeat (3) tick();
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
